io_timer: RTL

Memory-mapped two-channel timer/counter peripheral on the CPU's IO bus. It answers the IORead/IOWrite strobes that the control unit raises for Sw/Lw to the high IO page, selected by the address decoder's `timerCtrl` chip-select. Each channel either counts down on the system clock (timer) or on rising edges of an external pulse (counter). Each channel reports a one-cycle terminal-count pulse and readable status/count registers.

---
 rtl/io_timer_if.sv | 11 +
 rtl/io_timer.sv | 91 +++++++++
 2 files changed

// File: rtl/io_timer_if.sv
// io_timer_if: IO bus strobes, address and data between control unit and io_timer.
interface io_timer_if;
  logic IORead;
  logic IOWrite;
  logic timerCtrl;
  logic [2:0] address;
  logic [15:0] iowrite_data;
  logic [15:0] ioread_data;
  modport master(output IORead, IOWrite, timerCtrl, address, iowrite_data, input ioread_data);
  modport slave(input IORead, IOWrite, timerCtrl, address, iowrite_data, output ioread_data);
endinterface

// File: rtl/io_timer.sv
// io_timer: two-channel memory-mapped timer/counter with terminal-count pulses.
module io_timer_ch #(parameter int PRESCALE = 1) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pulse,
  input  logic        ctrl_wr,
  input  logic        init_wr,
  input  logic        status_rd,
  input  logic [15:0] wdata,
  output logic        running,
  output logic        done,
  output logic        cout,
  output logic [15:0] count
);
  logic mode, rpt, tick, dec, term;
  logic [15:0] init, pre;
  logic [2:0] sync;
  // sync[1] is the synchronized pulse, sync[2] its delayed copy for edge detection
  always_comb begin
    tick = pre == 16'(PRESCALE - 1);
    dec = running & (mode ? sync[1] & ~sync[2] : tick);
    term = running & (count == 16'd0 | (dec & count == 16'd1));
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      mode <= 1'b0;
      rpt <= 1'b0;
      init <= 16'd0;
      count <= 16'd0;
      pre <= 16'd0;
      running <= 1'b0;
      done <= 1'b0;
      cout <= 1'b0;
      sync <= 3'd0;
    end else begin
      sync <= {sync[1:0], pulse};
      cout <= term & ~ctrl_wr;
      if (init_wr) init <= wdata;
      if (ctrl_wr) begin
        mode <= wdata[0];
        rpt <= wdata[1];
        count <= init;
        running <= 1'b1;
        done <= 1'b0;
        pre <= 16'd0;
      end else begin
        pre <= (!running || tick) ? 16'd0 : pre + 16'd1;
        done <= term | (done & ~status_rd);
        // a zero count reached by loading INIT=0 never reloads, avoiding an endless pulse train
        if (term) begin
          count <= (rpt && count != 16'd0) ? init : 16'd0;
          running <= rpt && count != 16'd0;
        end else if (dec) count <= count - 16'd1;
      end
    end
  end
endmodule

module io_timer #(parameter int PRESCALE = 1) (
  input  logic         clock,
  input  logic         reset,
  io_timer_if.slave    bus,
  input  logic         pulse0,
  input  logic         pulse1,
  output logic         cout0,
  output logic         cout1
);
  logic wr, rd, run0, run1, done0, done1, unused_addr0;
  logic [1:0] sel;
  logic [15:0] count0, count1;
  assign unused_addr0 = bus.address[0];
  always_comb begin
    wr = bus.IOWrite & bus.timerCtrl;
    rd = bus.IORead & bus.timerCtrl;
    sel = bus.address[2:1];
    bus.ioread_data = !rd ? 16'h0000 :
                      sel == 2'd0 ? {14'd0, done0, run0} :
                      sel == 2'd1 ? {14'd0, done1, run1} :
                      sel == 2'd2 ? count0 : count1;
  end
  io_timer_ch #(.PRESCALE(PRESCALE)) ch0 (
    .clock(clock), .reset(reset), .pulse(pulse0),
    .ctrl_wr(wr && sel == 2'd0), .init_wr(wr && sel == 2'd2), .status_rd(rd && sel == 2'd0),
    .wdata(bus.iowrite_data), .running(run0), .done(done0), .cout(cout0), .count(count0)
  );
  io_timer_ch #(.PRESCALE(PRESCALE)) ch1 (
    .clock(clock), .reset(reset), .pulse(pulse1),
    .ctrl_wr(wr && sel == 2'd1), .init_wr(wr && sel == 2'd3), .status_rd(rd && sel == 2'd1),
    .wdata(bus.iowrite_data), .running(run1), .done(done1), .cout(cout1), .count(count1)
  );
endmodule
